// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_pkg;

    localparam int DW    = 64;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [DW-1:0] addr);
        return |addr[2:0];
    endfunction

endpackage

// File: rtl/dm_storage.sv
// Doubleword array: synchronous write, registered read on enable, sync clear.
module dm_storage
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH_WORDS];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle load/store target: accepts one request, waits LATENCY cycles,
// performs the access and holds the response until it is taken.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 2
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [DW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_error,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [DW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             error_q, error_d;

    logic          acc_fire;
    logic          acc_write;
    logic [DW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          acc_err;
    logic [DW-1:0] mem_rdata;

    // With zero latency the access uses the live request, not the capture.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign acc_err = is_misaligned(acc_addr) || (|(acc_addr >> (3 + AW)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        error_d  = error_q;
        acc_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        acc_fire = 1'b1;
                        error_d  = acc_err;
                        state_d  = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    acc_fire = 1'b1;
                    error_d  = acc_err;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
        end
    end

    dm_storage #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_storage (
        .clk  (clk),
        .Reset(Reset),
        .we   (acc_fire & acc_write & ~acc_err),
        .waddr(acc_addr[3 +: AW]),
        .wdata(acc_wdata),
        .re   (acc_fire & ~acc_write & ~acc_err),
        .raddr(acc_addr[3 +: AW]),
        .rdata(mem_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_error = rsp_valid & error_q;
    assign rsp_rdata = (rsp_valid && !write_q && !error_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table plus multi-cycle sequences.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        Reset;

    logic        req_valid, req_write, rsp_ready;
    logic [63:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_error, busy;
    logic [63:0] rsp_rdata;

    logic        z_req_valid, z_req_write, z_rsp_ready;
    logic [63:0] z_req_addr, z_req_wdata;
    logic        z_req_ready, z_rsp_valid, z_rsp_error, z_busy;
    logic [63:0] z_rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(32), .LATENCY(2)) dut (
        .clk(clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy)
    );

    dm_responder #(.DEPTH_WORDS(32), .LATENCY(0)) dut0 (
        .clk(clk), .Reset(Reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error), .busy(z_busy)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [63:0] a,
                          input logic [63:0] d, output logic [63:0] rd,
                          output logic er, output int lat);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_error;
        tick();
    endtask

    vec_t        vecs [10];
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        vecs[0] = '{"ld_0x10_after_reset", 1'b0, 64'h10,  64'h0, 64'h0, 1'b0};
        vecs[1] = '{"st_0x18",    1'b1, 64'h18,  64'hDEADBEEF, 64'h0, 1'b0};
        vecs[2] = '{"ld_0x18",    1'b0, 64'h18,  64'h0, 64'hDEADBEEF, 1'b0};
        vecs[3] = '{"st_misalign",1'b1, 64'h1C,  64'h1234, 64'h0, 1'b1};
        vecs[4] = '{"ld_oor",     1'b0, 64'h100, 64'h0, 64'h0, 1'b1};
        vecs[5] = '{"ld_0x18_kept",1'b0,64'h18,  64'h0, 64'hDEADBEEF, 1'b0};
        vecs[6] = '{"st_last",    1'b1, 64'hF8,  64'hAAAA5555, 64'h0, 1'b0};
        vecs[7] = '{"ld_last",    1'b0, 64'hF8,  64'h0, 64'hAAAA5555, 1'b0};
        vecs[8] = '{"ld_0x0",     1'b0, 64'h0,   64'h0, 64'h0, 1'b0};
        vecs[9] = '{"st_0x09",    1'b1, 64'h09,  64'h77, 64'h0, 1'b1};

        Reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0;
        z_req_wdata = '0; z_rsp_ready = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);

        foreach (vecs[i]) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'd2);
            chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            chk({vecs[i].name, "_err"}, 64'(er), 64'(vecs[i].exp_err));
            chk({vecs[i].name, "_one_cycle"}, 64'(rsp_valid), 64'd0);
            chk({vecs[i].name, "_ready_back"}, 64'(req_ready), 64'd1);
        end

        // backpressure on a load of 0x18
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h18;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", 64'(rsp_valid), 64'd1);
            chk("bp_rdata_hold", rsp_rdata, 64'hDEADBEEF);
            chk("bp_no_accept", 64'(req_ready), 64'd0);
            if (i == 4) rsp_ready = 1'b1;
            tick();
        end
        chk("bp_ready_after", 64'(req_ready), 64'd1);
        chk("bp_valid_drop", 64'(rsp_valid), 64'd0);
        tick();
        req_valid = 1'b0;
        chk("bp_held_accepted", 64'(busy), 64'd1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("bp_held_rdata", rsp_rdata, 64'h0);
        tick();

        // reset while a store waits
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h08;
        req_wdata = 64'h55;
        tick();
        req_valid = 1'b0;
        chk("rw_in_wait", 64'(busy), 64'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rw_req_ready", 64'(req_ready), 64'd1);
        chk("rw_busy", 64'(busy), 64'd0);
        do_req(1'b0, 64'h08, 64'h0, rd, er, lat);
        chk("rw_ld_0x08", rd, 64'h0);
        do_req(1'b0, 64'h18, 64'h0, rd, er, lat);
        chk("rw_mem_cleared", rd, 64'h0);

        // zero latency back-to-back
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 64'h0;
        z_req_wdata = 64'h7;
        chk("z_ready", 64'(z_req_ready), 64'd1);
        tick();
        chk("z_st_rsp", 64'(z_rsp_valid), 64'd1);
        chk("z_st_rdata", z_rsp_rdata, 64'h0);
        chk("z_st_err", 64'(z_rsp_error), 64'd0);
        z_req_write = 1'b0; z_req_wdata = 64'h0;
        chk("z_resp_no_ready", 64'(z_req_ready), 64'd0);
        tick();
        chk("z_idle_ready", 64'(z_req_ready), 64'd1);
        chk("z_idle_no_rsp", 64'(z_rsp_valid), 64'd0);
        tick();
        z_req_valid = 1'b0;
        chk("z_ld_rsp", 64'(z_rsp_valid), 64'd1);
        chk("z_ld_rdata", z_rsp_rdata, 64'h7);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
